// File: rtl/xconvenc_ctrl_pkg.sv
// xconvenc_ctrl_pkg: shared definitions for the convolutional encoder frame
// sequencer.
//   - state_t   : sequencer state encoding (IDLE..FIN)
//   - TAIL_LEN  : number of zero bits that flush the K=7 trellis
//   - G0 / G1   : generator polynomials (171, 133 octal). The encoder and the
//                 bench reference model both use them.
package xconvenc_ctrl_pkg;

    localparam int LEN_W_DEF = 16;
    localparam int TAIL_LEN  = 6;

    localparam logic [6:0] G0 = 7'o171;
    localparam logic [6:0] G1 = 7'o133;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_TAIL  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

endpackage

// File: rtl/xconvenc_ctrl_if.sv
// xconvenc_ctrl_if: control, byte-input and coded-pair-output signals of the
// frame sequencer, bundled as one interface.
//   master modport : frame source / pair sink (drives start, frame_len,
//                    s_data, s_valid, m_ready)
//   slave modport  : the sequencer (drives busy, done, s_ready, m_bits,
//                    m_valid, m_last)
interface xconvenc_ctrl_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic             busy;
    logic             done;
    logic [7:0]       s_data;
    logic             s_valid;
    logic             s_ready;
    logic [1:0]       m_bits;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;

    modport master (
        output start, frame_len, s_data, s_valid, m_ready,
        input  busy, done, s_ready, m_bits, m_valid, m_last
    );

    modport slave (
        input  start, frame_len, s_data, s_valid, m_ready,
        output busy, done, s_ready, m_bits, m_valid, m_last
    );
endinterface

// File: rtl/xconvenc_ctrl_enc.sv
// xconvenc: rate-1/2, K=7 convolutional encoder core (g0=171, g1=133 octal).
// Ports:
//   clk      in  clock
//   rst      in  synchronous active-high clear of the 6-bit history
//   en       in  advance the history by one input bit
//   bit_in   in  current input bit
//   bits_out out [0]=g0 output, [1]=g1 output for bit_in (combinational)
module xconvenc
    import xconvenc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       bit_in,
    output logic [1:0] bits_out
);
    // hist[5] is the most recent past bit, hist[0] the oldest. With bit_in on
    // top, the 7-bit window lines up with the generator MSB-first.
    logic [5:0] hist;
    logic [6:0] win;

    assign win      = {bit_in, hist};
    assign bits_out = {^(win & G1), ^(win & G0)};

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '0;
        end else if (en) begin
            hist <= {bit_in, hist[5:1]};
        end
    end
endmodule

// File: rtl/xconvenc_ctrl.sv
// xconvenc_ctrl: frame sequencer for the K=7 rate-1/2 convolutional encoder.
// Takes frame_len bytes on the s_* stream and feeds them MSB-first into the
// encoder. Coded pairs go out on the back-pressured m_* stream.
// Ports:
//   clk  in  clock
//   rst  in  synchronous active-high reset
//   bus  xconvenc_ctrl_if.slave : start/frame_len/busy/done control,
//        s_data/s_valid/s_ready byte input, m_bits/m_valid/m_ready/m_last
//        pair output
// Build option: XCONVENC_CTRL_TAIL_EN appends six zero tail bits per frame
// and puts m_last on the final tail pair. Without it, m_last sits on the
// final data pair and the trellis is left open.
module xconvenc_ctrl
    import xconvenc_ctrl_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    xconvenc_ctrl_if.slave   bus
);
    state_t           state;
    logic [LEN_W-1:0] bytes_left;
    logic [7:0]       sreg;
    logic [2:0]       bit_cnt;

    logic       busy_r, done_r, s_ready_r;
    logic [1:0] m_bits_r;
    logic       m_valid_r, m_last_r;

    logic       frame_clear;
    logic       step;
    logic       enc_bit;
    logic [1:0] enc_bits;

    // The encoder is cleared in the same cycle the start is accepted, so no
    // history leaks from a previous or aborted frame.
    assign frame_clear = (state == ST_IDLE) && bus.start && (bus.frame_len != '0);

    // Encoder steps only when the output register is free or being drained
    // this cycle. A stall therefore freezes both the pair and the trellis.
    assign step    = ((state == ST_SHIFT) || (state == ST_TAIL)) &&
                     (!m_valid_r || bus.m_ready);
    assign enc_bit = (state == ST_SHIFT) ? sreg[7] : 1'b0;

    xconvenc u_enc (
        .clk      (clk),
        .rst      (rst | frame_clear),
        .en       (step),
        .bit_in   (enc_bit),
        .bits_out (enc_bits)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            bytes_left <= '0;
            sreg       <= '0;
            bit_cnt    <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            s_ready_r  <= 1'b0;
            m_bits_r   <= '0;
            m_valid_r  <= 1'b0;
            m_last_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;

            // Output register: drop the pair on acceptance. A new step in the
            // same cycle overrides this with the next pair.
            if (m_valid_r && bus.m_ready) begin
                m_valid_r <= 1'b0;
                m_last_r  <= 1'b0;
            end
            if (step) begin
                m_bits_r  <= enc_bits;
                m_valid_r <= 1'b1;
                m_last_r  <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (frame_clear) begin
                        bytes_left <= bus.frame_len;
                        busy_r     <= 1'b1;
                        s_ready_r  <= 1'b1;
                        state      <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (bus.s_valid && s_ready_r) begin
                        sreg       <= bus.s_data;
                        bit_cnt    <= '0;
                        bytes_left <= bytes_left - LEN_W'(1);
                        s_ready_r  <= 1'b0;
                        state      <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (step) begin
                        sreg    <= {sreg[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            if (bytes_left != '0) begin
                                s_ready_r <= 1'b1;
                                state     <= ST_LOAD;
                            end else begin
`ifdef XCONVENC_CTRL_TAIL_EN
                                state    <= ST_TAIL;
`else
                                m_last_r <= 1'b1;
                                state    <= ST_FIN;
`endif
                            end
                        end
                    end
                end

                ST_TAIL: begin
                    if (step) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'(TAIL_LEN - 1)) begin
                            bit_cnt  <= '0;
                            m_last_r <= 1'b1;
                            state    <= ST_FIN;
                        end
                    end
                end

                ST_FIN: begin
                    // Done follows the cycle in which the last pair is taken.
                    if (!m_valid_r || bus.m_ready) begin
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.s_ready = s_ready_r;
    assign bus.m_bits  = m_bits_r;
    assign bus.m_valid = m_valid_r;
    assign bus.m_last  = m_last_r;
endmodule

// File: tb/tb_xconvenc_ctrl.sv
// tb_xconvenc_ctrl: randomized scoreboard bench for xconvenc_ctrl.
// Expected pairs are built at frame start by a convolution over the frame's
// bit sequence. A negedge monitor pops and compares them on every m_* handshake.
module tb_xconvenc_ctrl;
    import xconvenc_ctrl_pkg::*;

`ifdef XCONVENC_CTRL_TAIL_EN
    localparam int NTAIL = 6;
`else
    localparam int NTAIL = 0;
`endif

    typedef struct packed {
        logic [1:0] bits;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    xconvenc_ctrl_if #(.LEN_W(16)) bus ();

    xconvenc_ctrl #(.LEN_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   mode     = 0;   // m_ready pattern: 0 high, 1 toggle, 2 random, 3 low
    int   pops     = 0;
    int   done_cnt = 0;
    int   t_done   = 0;
    int   t_start  = 0;
    bit   done_due = 0;
    bit   held     = 0;
    logic [1:0] held_bits;
    exp_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: each output bit is the XOR of generator taps over the last
    // seven input bits of the frame (data MSB-first, then the zero tail).
    function automatic void push_frame(input logic [7:0] bytes[$]);
        bit   u[$];
        exp_t e;
        bit   g0, g1;
        foreach (bytes[j])
            for (int i = 7; i >= 0; i--) u.push_back(bytes[j][i]);
        for (int i = 0; i < NTAIL; i++) u.push_back(1'b0);
        for (int t = 0; t < u.size(); t++) begin
            g0 = 1'b0;
            g1 = 1'b0;
            for (int k = 0; k < 7; k++)
                if (t - k >= 0) begin
                    g0 ^= G0[6-k] & u[t-k];
                    g1 ^= G1[6-k] & u[t-k];
                end
            e.bits = {g1, g0};
            e.last = (t == u.size() - 1);
            exp_q.push_back(e);
        end
    endfunction

    // m_ready pattern driver
    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = ~bus.m_ready;
                2:       bus.m_ready = 1'($urandom_range(0, 1));
                default: bus.m_ready = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                held     = 0;
                done_due = 0;
            end else begin
                if (done_due) begin
                    chk(bus.done === 1'b1, "done_after_last", int'(bus.done), 1);
                    done_due = 0;
                    t_done   = cyc;
                    done_cnt++;
                end else if (bus.done) begin
                    chk(1'b0, "spurious_done", 1, 0);
                end
                if (held && bus.m_valid)
                    chk(bus.m_bits == held_bits, "stall_hold", int'(bus.m_bits), int'(held_bits));
                held = 0;
                if (bus.m_valid && bus.m_ready) begin
                    pops++;
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "unexpected_pair", int'(bus.m_bits), 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk({bus.m_last, bus.m_bits} == {e.last, e.bits}, "pair",
                            int'({bus.m_last, bus.m_bits}), int'({e.last, e.bits}));
                        if (e.last) done_due = 1;
                    end
                end else if (bus.m_valid) begin
                    held      = 1;
                    held_bits = bus.m_bits;
                end
            end
        end
    end

    task automatic start_frame(input int len, input logic [7:0] bytes[$]);
        if (len != 0) push_frame(bytes);
        bus.frame_len = 16'(len);
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        t_start   = cyc;
        chk(bus.s_ready == (len != 0), "s_ready_after_start", int'(bus.s_ready), int'(len != 0));
        chk(bus.busy == (len != 0), "busy_after_start", int'(bus.busy), int'(len != 0));
    endtask

    task automatic send_bytes(input logic [7:0] bytes[$], input bit gaps);
        int to;
        foreach (bytes[j]) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            bus.s_data  = bytes[j];
            bus.s_valid = 1'b1;
            to = 0;
            forever begin
                @(negedge clk);
                if (bus.s_ready) break;
                to++;
                if (to > 1000) begin
                    chk(1'b0, "s_ready_timeout", 0, 1);
                    bus.s_valid = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            #1;
            bus.s_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int want);
        int to = 0;
        while (done_cnt < want && to < 3000) begin
            @(posedge clk);
            to++;
        end
        chk(done_cnt == want, "done_count", done_cnt, want);
        #1;
        chk(bus.busy == 1'b0, "busy_cleared", int'(bus.busy), 0);
        chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string name);
        chk({bus.busy, bus.done, bus.s_ready, bus.m_valid, bus.m_bits, bus.m_last} == 7'd0,
            name, int'({bus.busy, bus.done, bus.s_ready, bus.m_valid, bus.m_bits, bus.m_last}), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=%0d required=0", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] q[$];
        int base, to, nd;
        bus.start = 1'b0; bus.frame_len = '0; bus.s_data = '0; bus.s_valid = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_outputs");
        rst = 1'b0;
        nd = 0;

        // Impulse, m_ready high: first-pair latency and total frame latency
        mode = 0;
        q = {8'h80};
        start_frame(1, q);
        send_bytes(q, 0);
        chk(bus.m_valid == 1'b0, "m_valid_N+1", int'(bus.m_valid), 0);
        @(posedge clk);
        #1;
        chk(bus.m_valid == 1'b1, "m_valid_N+2", int'(bus.m_valid), 1);
        nd++; wait_done(nd);
        chk(t_done - t_start == 9 + 1 + NTAIL, "impulse_latency", t_done - t_start, 10 + NTAIL);

        // Impulse with m_ready toggling every cycle
        mode = 1;
        start_frame(1, q);
        send_bytes(q, 0);
        nd++; wait_done(nd);

        // Multi-byte with random s_valid gaps and random back-pressure
        mode = 2;
        q = {8'hA5, 8'h3C, 8'hFF};
        start_frame(3, q);
        send_bytes(q, 1);
        nd++; wait_done(nd);

        // Multi-byte streaming: exactly one LOAD bubble per byte
        mode = 0;
        q = {8'($urandom), 8'($urandom), 8'($urandom)};
        start_frame(3, q);
        send_bytes(q, 0);
        nd++; wait_done(nd);
        chk(t_done - t_start == 27 + 1 + NTAIL, "stream_latency", t_done - t_start, 28 + NTAIL);

        // Zero-length start is ignored
        q = {};
        start_frame(0, q);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk(bus.busy == 1'b0 && bus.s_ready == 1'b0, "zero_len_idle",
                int'({bus.busy, bus.s_ready}), 0);
        end

        // start pulse mid-frame is ignored
        mode = 2;
        q = {8'($urandom), 8'($urandom)};
        start_frame(2, q);
        fork
            send_bytes(q, 1);
            begin
                repeat (6) @(posedge clk);
                #1;
                bus.frame_len = 16'd5;
                bus.start     = 1'b1;
                @(posedge clk);
                #1;
                bus.start = 1'b0;
            end
        join
        nd++; wait_done(nd);
        repeat (4) @(posedge clk);
        #1;
        chk(bus.busy == 1'b0, "no_restart_after_busy_start", int'(bus.busy), 0);

        // Reset after pair 5 of a 2-byte frame, then a clean impulse
        mode = 0;
        q = {8'hC3, 8'h5A};
        start_frame(2, q);
        q = {8'hC3};
        base = pops;
        send_bytes(q, 0);
        to = 0;
        while (pops < base + 5 && to < 200) begin
            @(posedge clk);
            to++;
        end
        chk(pops >= base + 5, "reached_pair5", pops - base, 5);
        #2;
        mode = 3;
        bus.m_ready = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check_idle_outputs("midframe_reset_outputs");
        rst = 1'b0;
        mode = 0;
        q = {8'h80};
        start_frame(1, q);
        send_bytes(q, 0);
        nd++; wait_done(nd);

        // Random frames, random gaps and back-pressure
        mode = 2;
        for (int f = 0; f < 4; f++) begin
            int len;
            len = $urandom_range(1, 4);
            q = {};
            for (int b = 0; b < len; b++) q.push_back(8'($urandom));
            start_frame(len, q);
            send_bytes(q, 1);
            nd++; wait_done(nd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
